// File: rtl/uart_pkg.sv
// Constants shared by the UART receive path: default FIFO depth and byte width.
package uart_pkg;

    localparam int UART_FIFO_DEPTH_DEFAULT = 16;
    localparam int UART_DATA_W             = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO byte storage: one synchronous write port and an asynchronous read port,
// so it maps onto distributed RAM. Contents are never reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  uart_byte_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output uart_byte_t    rdata_o
);

    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: first-word fall-through byte queue with
// sticky error flags, fill-level interrupt and an idle timeout interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             RxReady,
    input  uart_byte_t       RxData,
    input  logic             RxParityErr,
    input  logic             RxFrameErr,
    input  logic             RdEn,
    input  logic             Flush,
    input  logic             ClrErr,
    input  logic [CW-1:0]    IrqThreshold,
    input  logic [15:0]      TimeoutLimit,
    output uart_byte_t       RdData,
    output logic             Empty,
    output logic             Full,
    output logic [CW-1:0]    Count,
    output logic             OverrunErr,
    output logic             ParityErrSticky,
    output logic             FrameErrSticky,
    output logic             IrqData,
    output logic             IrqTimeout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          par_q, par_d;
    logic          frm_q, frm_d;
    logic          irq_data_q, irq_data_d;
    logic [15:0]   tmo_q, tmo_d;

    logic empty_w, full_w;
    logic rx_err, do_pop, do_write, overrun_evt, mem_we;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    always_comb begin
        rx_err      = RxParityErr | RxFrameErr;
        do_pop      = RdEn && !empty_w;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        do_write    = RxReady && !rx_err && (!full_w || do_pop);
        overrun_evt = RxReady && !rx_err && full_w && !do_pop && !Flush;
        mem_we      = do_write && !Flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_write) - CW'(do_pop);
        end

        // Set events win over a concurrent clear.
        ovr_d = ovr_q;
        par_d = par_q;
        frm_d = frm_q;
        if (ClrErr) begin
            ovr_d = 1'b0;
            par_d = 1'b0;
            frm_d = 1'b0;
        end
        if (overrun_evt) ovr_d = 1'b1;
        if (RxParityErr) par_d = 1'b1;
        if (RxFrameErr)  frm_d = 1'b1;

        irq_data_d = (count_q >= IrqThreshold) && (IrqThreshold != '0);

        tmo_d = tmo_q;
        if (Flush || do_write || do_pop || empty_w) begin
            tmo_d = '0;
        end else if (tmo_q < TimeoutLimit) begin
            tmo_d = tmo_q + 16'd1;
        end else begin
            tmo_d = TimeoutLimit;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            par_q      <= 1'b0;
            frm_q      <= 1'b0;
            irq_data_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            par_q      <= par_d;
            frm_q      <= frm_d;
            irq_data_q <= irq_data_d;
            tmo_q      <= tmo_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (Clock),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (RxData),
        .raddr_i (rd_ptr_q),
        .rdata_o (RdData)
    );

    assign Empty           = empty_w;
    assign Full            = full_w;
    assign Count           = count_q;
    assign OverrunErr      = ovr_q;
    assign ParityErrSticky = par_q;
    assign FrameErrSticky  = frm_q;
    assign IrqData         = irq_data_q;
    assign IrqTimeout      = (tmo_q == TimeoutLimit) && (TimeoutLimit != 16'd0) && !empty_w;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a byte queue holds expected FIFO contents,
// every pop compares the fall-through head against the queue front.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          Clock = 1'b0;
    logic          Reset, RxReady, RxParityErr, RxFrameErr, RdEn, Flush, ClrErr;
    logic [7:0]    RxData;
    logic [CW-1:0] IrqThreshold;
    logic [15:0]   TimeoutLimit;
    logic [7:0]    RdData;
    logic          Empty, Full, OverrunErr, ParityErrSticky, FrameErrSticky;
    logic          IrqData, IrqTimeout;
    logic [CW-1:0] Count;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clock(Clock), .Reset(Reset), .RxReady(RxReady), .RxData(RxData),
        .RxParityErr(RxParityErr), .RxFrameErr(RxFrameErr), .RdEn(RdEn),
        .Flush(Flush), .ClrErr(ClrErr), .IrqThreshold(IrqThreshold),
        .TimeoutLimit(TimeoutLimit), .RdData(RdData), .Empty(Empty), .Full(Full),
        .Count(Count), .OverrunErr(OverrunErr), .ParityErrSticky(ParityErrSticky),
        .FrameErrSticky(FrameErrSticky), .IrqData(IrqData), .IrqTimeout(IrqTimeout)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit accepted);
        RxReady = 1'b1;
        RxData  = b;
        step();
        RxReady = 1'b0;
        if (accepted) sb.push_back(b);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] exp_b;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed pop expected nonempty scoreboard", tag);
        end else begin
            exp_b = sb.pop_front();
            check(tag, {8'h0, RdData}, {8'h0, exp_b});
        end
        RdEn = 1'b1;
        step();
        RdEn = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; RxReady = 0; RxParityErr = 0; RxFrameErr = 0; RdEn = 0;
        Flush = 0; ClrErr = 0; RxData = 8'h00; IrqThreshold = '0; TimeoutLimit = 16'd0;
        step(); step();
        Reset = 1'b0;
        check("rst_count", 16'(Count), 16'd0);
        check("rst_empty", 16'(Empty), 16'd1);
        check("rst_full", 16'(Full), 16'd0);
        check("rst_sticky", {13'd0, OverrunErr, ParityErrSticky, FrameErrSticky}, 16'd0);
        check("rst_irq", {14'd0, IrqData, IrqTimeout}, 16'd0);

        // Basic write/read
        push(8'hA5, 1); push(8'h3C, 1);
        check("basic_cnt2", 16'(Count), 16'd2);
        pop_chk("basic_rd0");
        check("basic_cnt1", 16'(Count), 16'd1);
        pop_chk("basic_rd1");
        check("basic_cnt0", 16'(Count), 16'd0);
        check("basic_empty", 16'(Empty), 16'd1);

        // Fill past capacity
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), i < DEPTH);
        check("fill_full", 16'(Full), 16'd1);
        check("fill_count", 16'(Count), 16'(DEPTH));
        check("fill_overrun", 16'(OverrunErr), 16'd1);
        ClrErr = 1'b1; step(); ClrErr = 1'b0;
        check("clr_overrun", 16'(OverrunErr), 16'd0);

        // Simultaneous write and pop while full
        RxReady = 1'b1; RxData = 8'hEE;
        pop_chk("full_wrpop_head");
        RxReady = 1'b0;
        sb.push_back(8'hEE);
        check("full_wrpop_cnt", 16'(Count), 16'(DEPTH));
        check("full_wrpop_ovr", 16'(OverrunErr), 16'd0);
        for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("drain_%0d", i));
        check("drain_empty", 16'(Empty), 16'd1);

        // Pop on empty ignored; write+pop on empty accepts the write
        RdEn = 1'b1; step(); RdEn = 1'b0;
        check("under_count", 16'(Count), 16'd0);
        RdEn = 1'b1; push(8'h77, 1); RdEn = 1'b0;
        check("emp_wrpop_cnt", 16'(Count), 16'd1);
        pop_chk("emp_wrpop_rd");

        // Data IRQ threshold
        IrqThreshold = CW'(4);
        push(8'h01, 1); push(8'h02, 1); push(8'h03, 1); push(8'h04, 1);
        check("irq_lag", 16'(IrqData), 16'd0);
        step();
        check("irq_rise", 16'(IrqData), 16'd1);
        pop_chk("irq_pop");
        check("irq_hold", 16'(IrqData), 16'd1);
        step();
        check("irq_fall", 16'(IrqData), 16'd0);
        IrqThreshold = '0;

        // Flush overrides a concurrent write, leaves sticky flags
        RxParityErr = 1'b1; step(); RxParityErr = 1'b0;
        Flush = 1'b1; push(8'h99, 0); Flush = 1'b0;
        sb.delete();
        check("flush_count", 16'(Count), 16'd0);
        check("flush_sticky", 16'(ParityErrSticky), 16'd1);
        ClrErr = 1'b1; step(); ClrErr = 1'b0;

        // Timeout IRQ
        TimeoutLimit = 16'd100;
        push(8'h42, 1);
        repeat (99) step();
        check("tmo_before", 16'(IrqTimeout), 16'd0);
        step();
        check("tmo_fire", 16'(IrqTimeout), 16'd1);
        repeat (5) step();
        check("tmo_sat", 16'(IrqTimeout), 16'd1);
        pop_chk("tmo_pop");
        check("tmo_clear", 16'(IrqTimeout), 16'd0);
        repeat (120) step();
        check("tmo_empty", 16'(IrqTimeout), 16'd0);
        TimeoutLimit = 16'd0;

        // Error strobes: set beats clear, byte discarded
        RxParityErr = 1'b1; ClrErr = 1'b1; push(8'h55, 0);
        RxParityErr = 1'b0; ClrErr = 1'b0;
        check("par_set", 16'(ParityErrSticky), 16'd1);
        check("par_cnt", 16'(Count), 16'd0);
        ClrErr = 1'b1; step(); ClrErr = 1'b0;
        check("par_clr", 16'(ParityErrSticky), 16'd0);
        RxFrameErr = 1'b1; push(8'h66, 0); RxFrameErr = 1'b0;
        check("frm_set", 16'(FrameErrSticky), 16'd1);
        check("frm_cnt", 16'(Count), 16'd0);

        // Reset mid-operation wins over a concurrent write
        push(8'hC1, 1); push(8'hC2, 1);
        Reset = 1'b1; push(8'hC3, 0); Reset = 1'b0;
        sb.delete();
        check("mid_rst_cnt", 16'(Count), 16'd0);
        check("mid_rst_empty", 16'(Empty), 16'd1);
        check("mid_rst_frm", 16'(FrameErrSticky), 16'd0);
        push(8'hD0, 1);
        pop_chk("post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
